tube_scan_decoder: RTL and testbench

Receive-side monitor for the multiplexed seven-segment scan bus driven by the traffic-light display controller. The block samples the 11-bit tube bus (3-bit digit select plus 8 segment lines) and decodes each segment pattern back to a BCD digit. It reassembles each scan frame into the original 6-bit count, and publishes the count once it is stable across several frames. It sits on the board-level display bus and feeds the self-check / status logic.

---
 rtl/tube_scan_decoder.sv | 179 +++++++++++++++++
 tb/tb_tube_scan_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tube_scan_decoder.sv
// tube_scan_decoder: rebuilds a 6-bit count from the muxed 7-seg scan bus.
// Define TUBE_ERR_CNT_EN to add the saturating err_count output.
module tube_scan_decoder #(
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] tube_11bit,
  output logic [5:0]  count,
  output logic        locked,
  output logic        count_upd,
  output logic        frame_err
`ifdef TUBE_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [3:0] SF = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    GOT_HIGH,
    GOT_LOW
  } state_t;

  state_t     state;
  state_t     nxt_state;
  logic [3:0] tens;
  logic [3:0] units;
  logic [5:0] cand;
  logic [3:0] match_cnt;

  logic [2:0] sel;
  logic [7:0] seg;
  logic       seg_ok;
  logic [3:0] seg_dig;
  logic [6:0] value;
  logic       blank_ok;
  logic       range_ok;

  logic       err;
  logic       done;
  logic       ld_tens;
  logic       ld_units;
  logic [5:0] cand_nxt;
  logic [3:0] cnt_nxt;
  logic       publish;

  assign sel = tube_11bit[10:8];
  assign seg = tube_11bit[7:0];

  // {valid, digit}; dp must be clear, anything unlisted is invalid
  function automatic logic [4:0] seg_decode(input logic [7:0] s);
    logic [4:0] r;
    unique case (s)
      8'h3F:   r = {1'b1, 4'd0};
      8'h06:   r = {1'b1, 4'd1};
      8'h5B:   r = {1'b1, 4'd2};
      8'h4F:   r = {1'b1, 4'd3};
      8'h66:   r = {1'b1, 4'd4};
      8'h6D:   r = {1'b1, 4'd5};
      8'h7D:   r = {1'b1, 4'd6};
      8'h07:   r = {1'b1, 4'd7};
      8'h7F:   r = {1'b1, 4'd8};
      8'h6F:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  assign {seg_ok, seg_dig} = seg_decode(seg);

  // digits are already latched when the blank slot arrives
  assign value    = 7'(tens) * 7'd10 + 7'(units);
  assign blank_ok = (seg == 8'h00);
  assign range_ok = (value <= 7'd63);

  // scan protocol: next state, digit strobes, error and frame-done
  always_comb begin
    nxt_state = state;
    err       = 1'b0;
    done      = 1'b0;
    ld_tens   = 1'b0;
    ld_units  = 1'b0;
    unique case (1'b1)
      sel == 3'd0: begin
        // a new frame always restarts here; an early restart is an error
        ld_tens   = seg_ok;
        err       = !seg_ok || (state != IDLE);
        nxt_state = seg_ok ? GOT_HIGH : IDLE;
      end
      sel == 3'd1: begin
        if (state == GOT_HIGH && seg_ok) begin
          ld_units  = 1'b1;
          nxt_state = GOT_LOW;
        end else if (state != IDLE) begin
          err       = 1'b1;
          nxt_state = IDLE;
        end
      end
      sel == 3'd2: begin
        if (state == GOT_LOW) begin
          done      = blank_ok && range_ok;
          err       = !(blank_ok && range_ok);
          nxt_state = IDLE;
        end else if (state == GOT_HIGH) begin
          err       = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: begin
        err       = 1'b1;
        nxt_state = IDLE;
      end
    endcase
  end

  // stability filter: count only moves after SF matching frames
  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = match_cnt;
    publish  = 1'b0;
    if (err) begin
      cnt_nxt = 4'd0;
    end else if (done) begin
      if (value[5:0] == cand) begin
        cnt_nxt = (match_cnt >= SF) ? SF : match_cnt + 4'd1;
      end else begin
        cand_nxt = value[5:0];
        cnt_nxt  = 4'd1;
      end
      publish = (cnt_nxt == SF) && ((count != cand_nxt) || !locked);
    end
  end

  // FSM, digit latches, filter state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tens      <= 4'd0;
      units     <= 4'd0;
      cand      <= 6'd0;
      match_cnt <= 4'd0;
      count     <= 6'd0;
      locked    <= 1'b0;
      count_upd <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= nxt_state;
      cand      <= cand_nxt;
      match_cnt <= cnt_nxt;
      count_upd <= publish;
      frame_err <= err;
      if (ld_tens) begin
        tens <= seg_dig;
      end
      if (ld_units) begin
        units <= seg_dig;
      end
      if (publish) begin
        count  <= cand_nxt;
        locked <= 1'b1;
      end
    end
  end

`ifdef TUBE_ERR_CNT_EN
  // saturating tally of error pulses, in step with frame_err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= 8'd0;
    end else if (err && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tube_scan_decoder.sv
// tb_tube_scan_decoder: directed scan-bus vectors, queue scoreboard.
// Build with TUBE_ERR_CNT_EN to also exercise err_count.
module tb_tube_scan_decoder;

  localparam int EV_NONE = 0;
  localparam int EV_UPD  = 1;
  localparam int EV_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] tube_11bit = {3'd2, 8'h00};
  logic [5:0]  count;
  logic        locked;
  logic        count_upd;
  logic        frame_err;
`ifdef TUBE_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  tube_scan_decoder #(.STABLE_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .tube_11bit (tube_11bit),
    .count      (count),
    .locked     (locked),
    .count_upd  (count_upd),
    .frame_err  (frame_err)
`ifdef TUBE_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [5:0] cnt;
    logic       lck;
    time        t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_exp = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // one bus sample; an expected event shows up one cycle later
  task automatic put(input logic [2:0] s, input logic [7:0] g,
                     input int ev, input logic [5:0] c,
                     input logic l);
    exp_t e;
    @(negedge clk);
    tube_11bit = {s, g};
    if (ev != EV_NONE) begin
      e.kind = ev;
      e.cnt  = c;
      e.lck  = l;
      e.t    = $time + 10;
      sb.push_back(e);
      if (ev == EV_ERR) err_exp++;
    end
  endtask

  task automatic frame(input logic [7:0] g0, input logic [7:0] g1,
                       input logic [7:0] g2, input int ev,
                       input logic [5:0] c, input logic l);
    put(3'd0, g0, EV_NONE, 6'd0, 1'b0);
    put(3'd1, g1, EV_NONE, 6'd0, 1'b0);
    put(3'd2, g2, ev, c, l);
  endtask

  // monitor: every output pulse must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (rst && (count_upd || frame_err)) begin
      k = (count_upd && frame_err) ? 3 : (count_upd ? EV_UPD : EV_ERR);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_pulse: kind %0d at %0t, none expected",
                 k, $time);
      end else begin
        e = sb.pop_front();
        if (e.kind != k || e.t != $time ||
            count != e.cnt || locked != e.lck) begin
          n_bad++;
          $display("FAIL event: got kind %0d t %0t count %0d lock %0d want kind %0d t %0t count %0d lock %0d",
                   k, $time, count, locked, e.kind, e.t, e.cnt, e.lck);
        end
      end
    end
  end

  initial begin
    #2;
    chk("rst_count", count, 0);
    chk("rst_locked", locked, 0);
    chk("rst_upd", count_upd, 0);
    chk("rst_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b1;

    // 37 twice -> one update, third frame silent
    frame(8'h4F, 8'h07, 8'h00, EV_NONE, 6'd0, 1'b0);
    frame(8'h4F, 8'h07, 8'h00, EV_UPD, 6'd37, 1'b1);
    frame(8'h4F, 8'h07, 8'h00, EV_NONE, 6'd0, 1'b0);

    // switch to 12; count holds 37 after the first 12 frame
    frame(8'h06, 8'h5B, 8'h00, EV_NONE, 6'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("hold_37", count, 37);
    frame(8'h06, 8'h5B, 8'h00, EV_UPD, 6'd12, 1'b1);
    frame(8'h06, 8'h5B, 8'h00, EV_NONE, 6'd0, 1'b0);

    // 64 is out of range
    frame(8'h7D, 8'h66, 8'h00, EV_ERR, 6'd12, 1'b1);
    frame(8'h7D, 8'h66, 8'h00, EV_ERR, 6'd12, 1'b1);

    // select 0 then 2; trailing 1,2 ignored in IDLE
    put(3'd0, 8'h4F, EV_NONE, 6'd0, 1'b0);
    put(3'd2, 8'h00, EV_ERR, 6'd12, 1'b1);
    put(3'd1, 8'h07, EV_NONE, 6'd0, 1'b0);
    put(3'd2, 8'h00, EV_NONE, 6'd0, 1'b0);
    frame(8'h4F, 8'h07, 8'h00, EV_NONE, 6'd0, 1'b0);
    frame(8'h4F, 8'h07, 8'h00, EV_UPD, 6'd37, 1'b1);

    // select 5 mid-frame
    put(3'd0, 8'h4F, EV_NONE, 6'd0, 1'b0);
    put(3'd5, 8'h00, EV_ERR, 6'd37, 1'b1);
    put(3'd2, 8'h00, EV_NONE, 6'd0, 1'b0);

    // early select 0 restarts the frame, which then completes
    put(3'd0, 8'h4F, EV_NONE, 6'd0, 1'b0);
    put(3'd1, 8'h07, EV_NONE, 6'd0, 1'b0);
    put(3'd0, 8'h4F, EV_ERR, 6'd37, 1'b1);
    put(3'd1, 8'h07, EV_NONE, 6'd0, 1'b0);
    put(3'd2, 8'h00, EV_NONE, 6'd0, 1'b0);
    frame(8'h4F, 8'h07, 8'h00, EV_NONE, 6'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("relock_37", count, 37);
    chk("relock_lock", locked, 1);

    // bad blank, bad digit bytes, dp set
    frame(8'h4F, 8'h07, 8'h80, EV_ERR, 6'd37, 1'b1);
    put(3'd0, 8'h3E, EV_ERR, 6'd37, 1'b1);
    put(3'd1, 8'h07, EV_NONE, 6'd0, 1'b0);
    put(3'd2, 8'h00, EV_NONE, 6'd0, 1'b0);
    put(3'd0, 8'hBF, EV_ERR, 6'd37, 1'b1);
    put(3'd2, 8'h00, EV_NONE, 6'd0, 1'b0);
    put(3'd0, 8'h4F, EV_NONE, 6'd0, 1'b0);
    put(3'd1, 8'h3E, EV_ERR, 6'd37, 1'b1);
    put(3'd2, 8'h00, EV_NONE, 6'd0, 1'b0);

`ifdef TUBE_ERR_CNT_EN
    @(posedge clk);
    #1;
    chk("err_count", err_count, err_exp);
`endif

    // reset while in GOT_LOW
    put(3'd0, 8'h3F, EV_NONE, 6'd0, 1'b0);
    put(3'd1, 8'h6D, EV_NONE, 6'd0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_locked", locked, 0);
    chk("arst_upd", count_upd, 0);
    chk("arst_err", frame_err, 0);
`ifdef TUBE_ERR_CNT_EN
    chk("arst_errcnt", err_count, 0);
`endif
    err_exp = 0;
    tube_11bit = {3'd2, 8'h00};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 00 matches the reset candidate; still must publish once
    frame(8'h3F, 8'h3F, 8'h00, EV_NONE, 6'd0, 1'b0);
    frame(8'h3F, 8'h3F, 8'h00, EV_UPD, 6'd0, 1'b1);
    // 63 is the largest legal value
    frame(8'h7D, 8'h4F, 8'h00, EV_NONE, 6'd0, 1'b0);
    frame(8'h7D, 8'h4F, 8'h00, EV_UPD, 6'd63, 1'b1);
    put(3'd3, 8'h00, EV_ERR, 6'd63, 1'b1);
    put(3'd2, 8'h00, EV_NONE, 6'd0, 1'b0);

`ifdef TUBE_ERR_CNT_EN
    for (int i = 0; i < 300; i++) begin
      put(3'd5, 8'h00, EV_ERR, 6'd63, 1'b1);
    end
    put(3'd2, 8'h00, EV_NONE, 6'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("err_sat", err_count, (err_exp > 255) ? 255 : err_exp);
`endif

    put(3'd2, 8'h00, EV_NONE, 6'd0, 1'b0);
    put(3'd2, 8'h00, EV_NONE, 6'd0, 1'b0);
    chk("sb_left", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
